// File: rtl/msg_queue_mc.sv
// rtl/msg_queue_mc.sv - multi-channel packet-to-message queue with round-robin bus presentation
// One circular FIFO per virtual channel; the selected message is presented chunk by chunk.
module msg_queue_mc #(
    parameter int FLIT_WIDTH        = 64,
    parameter int MAX_PACKET_LENGTH = 5,
    parameter int BUS_DATA_WIDTH    = 32,
    parameter int BUS_ADDRESS_WIDTH = 32,
    parameter int N_CHANNELS        = 2,
    parameter int QUEUE_DEPTH       = 4,
    parameter int READ_BURST_LENGTH = 8,
    parameter int N_BITS_BURST      = 7,
    localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [MAX_PACKET_LENGTH*FLIT_WIDTH-1:0] in_link_i,
    input  logic [MAX_PACKET_LENGTH-1:0]           in_sel_i,
    input  logic [CH_W-1:0]                        in_channel_i,
    input  logic                                   r_pkt_to_msg_i,
    output logic                                   g_pkt_to_msg_o,
    output logic                                   r_bus_arbitration_o,
    output logic [CH_W-1:0]                        channel_o,
    output logic [BUS_ADDRESS_WIDTH-1:0]           address_o,
    output logic [BUS_DATA_WIDTH-1:0]              data_o,
    output logic [BUS_DATA_WIDTH/8-1:0]            sel_o,
    output logic                                   transaction_type_o,
    output logic [N_BITS_BURST-1:0]                burst_length_o,
    input  logic                                   next_data_i,
    input  logic                                   retry_i,
    input  logic                                   message_transmitted_i,
    output logic [N_CHANNELS*OCC_W-1:0]            occupancy_o,
    output logic                                   protocol_error_o
);

    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int ND_W    = $clog2(MAX_PACKET_LENGTH + 1);
    localparam int R       = FLIT_WIDTH / BUS_DATA_WIDTH;
    localparam int DATA_W  = (MAX_PACKET_LENGTH - 1) * FLIT_WIDTH;
    localparam int N_WORDS = (MAX_PACKET_LENGTH - 1) * R;

    localparam logic [OCC_W-1:0]        OCC_FULL = OCC_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0]        PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [N_BITS_BURST-1:0] R_B      = N_BITS_BURST'(R);
    localparam logic [N_BITS_BURST-1:0] RD_BURST = N_BITS_BURST'(READ_BURST_LENGTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [FLIT_WIDTH-1:0] head_flit_q  [N_CHANNELS][QUEUE_DEPTH];
    logic [DATA_W-1:0]     data_flits_q [N_CHANNELS][QUEUE_DEPTH];
    logic [ND_W-1:0]       n_data_q     [N_CHANNELS][QUEUE_DEPTH];

    logic [PTR_W-1:0] head_ptr_q [N_CHANNELS];
    logic [PTR_W-1:0] head_ptr_d [N_CHANNELS];
    logic [PTR_W-1:0] tail_ptr_q [N_CHANNELS];
    logic [PTR_W-1:0] tail_ptr_d [N_CHANNELS];
    logic [OCC_W-1:0] count_q    [N_CHANNELS];
    logic [OCC_W-1:0] count_d    [N_CHANNELS];

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]         last_served_q, last_served_d;
    logic [N_BITS_BURST-1:0] chunk_q, chunk_d;
    logic                    done_q, done_d;
    logic                    grant_q, grant_d;
    logic                    err_q, err_d;

    logic                    enq, deq;
    logic                    rr_found;
    logic [CH_W-1:0]         rr_pick;
    logic [FLIT_WIDTH-1:0]   cur_head;
    logic [DATA_W-1:0]       cur_data;
    logic [ND_W-1:0]         cur_nd;
    logic                    is_read;
    logic [N_BITS_BURST-1:0] write_beats;
    logic [N_BITS_BURST-1:0] burst;
    logic [N_BITS_BURST-1:0] burst_last;
    logic [BUS_DATA_WIDTH-1:0] data_word;
    logic                    unused_bits;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= N_CHANNELS) s = s - N_CHANNELS;
        return CH_W'(s);
    endfunction

    // The grant register doubles as the capture strobe: data is written while it is high.
    assign grant_d = r_pkt_to_msg_i && !grant_q && (count_q[in_channel_i] < OCC_FULL);
    assign enq     = grant_q;
    assign deq     = (state_q == ACTIVE) && message_transmitted_i;

    always_ff @(posedge clk) begin
        if (grant_q) begin
            head_flit_q[in_channel_i][tail_ptr_q[in_channel_i]]  <= in_link_i[FLIT_WIDTH-1:0];
            data_flits_q[in_channel_i][tail_ptr_q[in_channel_i]] <=
                in_link_i[MAX_PACKET_LENGTH*FLIT_WIDTH-1:FLIT_WIDTH];
            n_data_q[in_channel_i][tail_ptr_q[in_channel_i]]     <=
                ND_W'($countones(in_sel_i[MAX_PACKET_LENGTH-1:1]));
        end
    end

    always_comb begin
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        count_d    = count_q;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (enq && (in_channel_i == CH_W'(c)))
                tail_ptr_d[c] = wrap_inc(tail_ptr_q[c]);
            if (deq && (cur_ch_q == CH_W'(c)))
                head_ptr_d[c] = wrap_inc(head_ptr_q[c]);
            if ((enq && (in_channel_i == CH_W'(c))) && !(deq && (cur_ch_q == CH_W'(c))))
                count_d[c] = count_q[c] + OCC_W'(1);
            else if (!(enq && (in_channel_i == CH_W'(c))) && (deq && (cur_ch_q == CH_W'(c))))
                count_d[c] = count_q[c] - OCC_W'(1);
        end
    end

    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_served_q;
        for (int i = 1; i <= N_CHANNELS; i++) begin
            if (!rr_found && (count_q[rr_next(last_served_q, i)] != '0)) begin
                rr_found = 1'b1;
                rr_pick  = rr_next(last_served_q, i);
            end
        end
    end

    assign cur_head    = head_flit_q[cur_ch_q][head_ptr_q[cur_ch_q]];
    assign cur_data    = data_flits_q[cur_ch_q][head_ptr_q[cur_ch_q]];
    assign cur_nd      = n_data_q[cur_ch_q][head_ptr_q[cur_ch_q]];
    assign is_read     = (cur_head[FLIT_WIDTH-1 -: 2] == 2'b11);
    assign write_beats = N_BITS_BURST'(cur_nd) * R_B;
    assign burst       = is_read ? RD_BURST :
                         ((write_beats == '0) ? N_BITS_BURST'(1) : write_beats);
    assign burst_last  = burst - N_BITS_BURST'(1);

    always_comb begin
        data_word = '0;
        for (int w = 0; w < N_WORDS; w++) begin
            if (chunk_q == N_BITS_BURST'(w))
                data_word = cur_data[w*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        end
    end

    // The pulse at the last chunk acknowledges the final beat; only one beyond that is an error.
    always_comb begin
        state_d       = state_q;
        cur_ch_d      = cur_ch_q;
        last_served_d = last_served_q;
        chunk_d       = chunk_q;
        done_d        = done_q;
        err_d         = 1'b0;
        case (state_q)
            IDLE: begin
                chunk_d = '0;
                done_d  = 1'b0;
                if (rr_found) begin
                    state_d  = ACTIVE;
                    cur_ch_d = rr_pick;
                end
            end
            ACTIVE: begin
                if (message_transmitted_i) begin
                    state_d       = IDLE;
                    chunk_d       = '0;
                    done_d        = 1'b0;
                    last_served_d = cur_ch_q;
                end else if (retry_i) begin
                    chunk_d = '0;
                    done_d  = 1'b0;
                end else if (next_data_i) begin
                    if (chunk_q == burst_last) begin
                        if (done_q) err_d  = 1'b1;
                        else        done_d = 1'b1;
                    end else begin
                        chunk_d = chunk_q + N_BITS_BURST'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr_q    <= '{default: '0};
            tail_ptr_q    <= '{default: '0};
            count_q       <= '{default: '0};
            state_q       <= IDLE;
            cur_ch_q      <= '0;
            last_served_q <= CH_W'(N_CHANNELS - 1);
            chunk_q       <= '0;
            done_q        <= 1'b0;
            grant_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            head_ptr_q    <= head_ptr_d;
            tail_ptr_q    <= tail_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            cur_ch_q      <= cur_ch_d;
            last_served_q <= last_served_d;
            chunk_q       <= chunk_d;
            done_q        <= done_d;
            grant_q       <= grant_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        occupancy_o = '0;
        for (int c = 0; c < N_CHANNELS; c++)
            occupancy_o[c*OCC_W +: OCC_W] = count_q[c];
    end

    assign g_pkt_to_msg_o      = grant_q;
    assign r_bus_arbitration_o = (state_q == ACTIVE);
    assign channel_o           = cur_ch_q;
    assign address_o           = cur_head[BUS_ADDRESS_WIDTH-1:0];
    assign data_o              = is_read ? '0 : data_word;
    assign sel_o               = '1;
    assign transaction_type_o  = !is_read;
    assign burst_length_o      = burst;
    assign protocol_error_o    = err_q;

    assign unused_bits = ^{in_sel_i[0], cur_head[FLIT_WIDTH-3:BUS_ADDRESS_WIDTH]};

endmodule

// File: tb/tb_msg_queue_mc.sv
// tb/tb_msg_queue_mc.sv - directed self-checking bench for msg_queue_mc
module tb_msg_queue_mc;

    localparam int FW  = 64;
    localparam int MPL = 5;
    localparam int BDW = 32;
    localparam int BAW = 32;
    localparam int NBB = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic [MPL*FW-1:0] in_link;
    logic [MPL-1:0]    in_sel;
    logic [0:0]        in_channel;
    logic              r_req;
    logic              g;
    logic              arb;
    logic [0:0]        channel;
    logic [BAW-1:0]    address;
    logic [BDW-1:0]    data;
    logic [BDW/8-1:0]  sel;
    logic              ttype;
    logic [NBB-1:0]    burst;
    logic              nd;
    logic              rt;
    logic              mt;
    logic [5:0]        occ;
    logic              perr;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    localparam logic [63:0] F1 = 64'hA1A1A1A1_B0B0B0B0;
    localparam logic [63:0] F2 = 64'hC3C3C3C3_D2D2D2D2;
    logic [31:0] words [4];

    msg_queue_mc dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_link_i             (in_link),
        .in_sel_i              (in_sel),
        .in_channel_i          (in_channel),
        .r_pkt_to_msg_i        (r_req),
        .g_pkt_to_msg_o        (g),
        .r_bus_arbitration_o   (arb),
        .channel_o             (channel),
        .address_o             (address),
        .data_o                (data),
        .sel_o                 (sel),
        .transaction_type_o    (ttype),
        .burst_length_o        (burst),
        .next_data_i           (nd),
        .retry_i               (rt),
        .message_transmitted_i (mt),
        .occupancy_o           (occ),
        .protocol_error_o      (perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wr_head(input logic [31:0] a);
        return {2'b00, 30'h0, a};
    endfunction

    function automatic logic [63:0] rd_head(input logic [31:0] a);
        return {2'b11, 30'h0, a};
    endfunction

    task automatic send(input string tag, input logic [0:0] ch, input logic [63:0] head,
                        input logic [4:0] s, output int l);
        in_channel = ch;
        in_link    = {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444, F2, F1, head};
        in_sel     = s;
        r_req      = 1'b1;
        l = 0;
        do begin
            tick();
            l++;
        end while (g !== 1'b1 && l < 16);
        chk({tag, "_grant"}, g, 1);
        tick();
        r_req = 1'b0;
    endtask

    task automatic pulse(input logic p_nd, input logic p_rt, input logic p_mt);
        nd = p_nd;
        rt = p_rt;
        mt = p_mt;
        tick();
        nd = 1'b0;
        rt = 1'b0;
        mt = 1'b0;
    endtask

    task automatic wait_arb(input string tag);
        int n;
        n = 0;
        while (arb !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        chk({tag, "_arb"}, arb, 1);
    endtask

    task automatic serve(input string tag, input logic [0:0] ch, input logic [31:0] a,
                         input logic [6:0] b);
        wait_arb(tag);
        chk({tag, "_ch"}, channel, ch);
        chk({tag, "_addr"}, address, a);
        chk({tag, "_burst"}, burst, b);
        pulse(1'b0, 1'b0, 1'b1);
        chk({tag, "_bubble"}, arb, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        words[0] = 32'hB0B0B0B0;
        words[1] = 32'hA1A1A1A1;
        words[2] = 32'hD2D2D2D2;
        words[3] = 32'hC3C3C3C3;
        rst = 1'b1; r_req = 1'b0; in_link = '0; in_sel = '0; in_channel = '0;
        nd = 1'b0; rt = 1'b0; mt = 1'b0;
        tick();
        tick();
        chk("rst_grant", g, 0);
        chk("rst_arb", arb, 0);
        chk("rst_occ", occ, 0);
        chk("rst_perr", perr, 0);
        chk("rst_channel", channel, 0);
        rst = 1'b0;
        tick();
        chk("idle_arb", arb, 0);

        // write, two data flits, channel 0
        send("t1", 1'b0, wr_head(32'h1000), 5'b00111, lat);
        chk("t1_grant_lat", lat, 1);
        chk("t1_occ", occ, {3'd0, 3'd1});
        chk("t1_arb_g1", arb, 0);
        tick();
        chk("t1_arb_g2", arb, 1);
        chk("t1_type", ttype, 1);
        chk("t1_burst", burst, 4);
        chk("t1_addr", address, 32'h1000);
        chk("t1_ch", channel, 0);
        chk("t1_sel", sel, 4'hF);
        chk("t1_data0", data, words[0]);
        for (int i = 1; i < 4; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            chk("t1_data_step", data, words[i]);
        end
        pulse(1'b1, 1'b0, 1'b0);
        chk("t1_last_beat_perr", perr, 0);
        chk("t1_last_beat_data", data, words[3]);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t1_pop_occ", occ, 0);
        chk("t1_pop_arb", arb, 0);

        // head_tail read on channel 1
        send("t2", 1'b1, rd_head(32'h2000), 5'b00001, lat);
        tick();
        chk("t2_arb", arb, 1);
        chk("t2_ch", channel, 1);
        chk("t2_type", ttype, 0);
        chk("t2_burst", burst, 8);
        chk("t2_data", data, 0);
        chk("t2_addr", address, 32'h2000);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t2_occ", occ, 0);

        // full channel 0 blocks only channel 0
        send("t3_a", 1'b0, wr_head(32'h100), 5'b00011, lat);
        send("t3_b", 1'b0, wr_head(32'h200), 5'b00011, lat);
        send("t3_c", 1'b0, wr_head(32'h300), 5'b00011, lat);
        send("t3_d", 1'b0, wr_head(32'h400), 5'b00011, lat);
        chk("t3_occ_full", occ, {3'd0, 3'd4});
        in_channel = 1'b0;
        in_link    = {64'h0, 64'h0, F2, F1, wr_head(32'h500)};
        in_sel     = 5'b00011;
        r_req      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_full_nogrant", g, 0);
        end
        r_req = 1'b0;
        tick();
        send("t3_ch1", 1'b1, rd_head(32'h600), 5'b00001, lat);
        chk("t3_ch1_lat", lat, 1);
        chk("t3_occ_both", occ, {3'd1, 3'd4});
        in_channel = 1'b0;
        in_link    = {64'h0, 64'h0, F2, F1, wr_head(32'h500)};
        r_req      = 1'b1;
        tick();
        chk("t3_wait_nogrant", g, 0);
        chk("t3_active_addr", address, 32'h100);
        chk("t3_active_ch", channel, 0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t3_pop_nogrant", g, 0);
        send("t3_5th", 1'b0, wr_head(32'h500), 5'b00011, lat);
        chk("t3_5th_lat", lat, 1);
        chk("t3_occ_refill", occ, {3'd1, 3'd4});
        serve("t3_s1", 1'b1, 32'h600, 7'd8);
        serve("t3_s2", 1'b0, 32'h200, 7'd2);
        serve("t3_s3", 1'b0, 32'h300, 7'd2);
        serve("t3_s4", 1'b0, 32'h400, 7'd2);
        serve("t3_s5_wrap", 1'b0, 32'h500, 7'd2);
        chk("t3_occ_empty", occ, 0);

        // round robin between two loaded channels
        send("t4_a", 1'b0, wr_head(32'h10), 5'b00001, lat);
        send("t4_b", 1'b1, wr_head(32'h20), 5'b00001, lat);
        send("t4_c", 1'b0, wr_head(32'h30), 5'b00001, lat);
        send("t4_d", 1'b1, wr_head(32'h40), 5'b00001, lat);
        chk("t4_occ", occ, {3'd2, 3'd2});
        serve("t4_s1", 1'b0, 32'h10, 7'd1);
        tick();
        chk("t4_resume1", arb, 1);
        serve("t4_s2", 1'b1, 32'h20, 7'd1);
        tick();
        chk("t4_resume2", arb, 1);
        serve("t4_s3", 1'b0, 32'h30, 7'd1);
        tick();
        chk("t4_resume3", arb, 1);
        serve("t4_s4", 1'b1, 32'h40, 7'd1);
        chk("t4_occ_empty", occ, 0);

        // retry
        send("t5", 1'b0, wr_head(32'h3000), 5'b00111, lat);
        wait_arb("t5");
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0);
        chk("t5_chunk3", data, words[3]);
        pulse(1'b0, 1'b1, 1'b0);
        chk("t5_retry_data", data, words[0]);
        chk("t5_retry_ch", channel, 0);
        chk("t5_retry_addr", address, 32'h3000);
        chk("t5_retry_arb", arb, 1);
        pulse(1'b0, 1'b1, 1'b1);
        chk("t5_both_arb", arb, 0);
        chk("t5_both_occ", occ, 0);

        // overrun error, then reset mid-burst
        send("t6", 1'b0, wr_head(32'h4000), 5'b00111, lat);
        wait_arb("t6");
        for (int i = 1; i <= 5; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            chk("t6_perr", perr, (i == 5) ? 1 : 0);
        end
        chk("t6_hold_data", data, words[3]);
        tick();
        chk("t6_perr_once", perr, 0);
        chk("t6_hold_data2", data, words[3]);
        chk("t6_occ", occ, {3'd0, 3'd1});
        rst = 1'b1;
        tick();
        chk("t6_rst_occ", occ, 0);
        chk("t6_rst_arb", arb, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("t6_discard_arb", arb, 0);
        chk("t6_discard_occ", occ, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
